alu_shift_sequencer: RTL and testbench
======================================

Name: alu_shift_sequencer

Overview:
Multi-cycle controller that sequences the single 32-bit left barrel shifter to implement all five shift/rotate ALU ops: SHL, SHR, SHRA, ROL and ROR.
- Right shifts use bit-reversal around the left shifter.
- Rotates and SHRA sign fill use a second shifter pass, ORed into an accumulator.
- Sits in the ALU shift slot and is driven by the control unit through a start/busy/done handshake.

Parameters:
None. Datapath is fixed at 32 bits and shifter amount at 6 bits to match the existing shifter.

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-high reset
start  input  1  request; accepted only in IDLE
op  input  3  000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR, 101-111 pass-through
in  input  32  operand to shift
amount  input  32  shift amount (full register value)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result valid from this cycle
result  output  32  shifted value; held until next accepted start

Behaviour:
- Reset (clr=1, any time, asynchronous): state=IDLE, busy=0, done=0, result=0, accumulator=0, latched operands=0. An op in progress is abandoned with no done pulse.
- Start acceptance: at a rising edge in IDLE with start=1, latch op, in, amount; clear accumulator; go to PASS1. start in any other state is ignored and has no effect on the op in progress.
- Effective amount n:
  - SHL/SHR/SHRA: n = 32 if amount[31:5] != 0, else amount[4:0] (saturating).
  - ROL/ROR: n = amount[4:0] (mod 32).
  - Pass-through: n = 0.
- Shifter input/amount per pass (rev = 32-bit bit reversal):
  - SHL: PASS1 in<<n.
  - SHR: PASS1 rev(rev(in)<<n).
  - SHRA: PASS1 rev(rev(in)<<n); PASS2 mask = ~rev(rev(32'hFFFFFFFF)<<n), ORed only if in[31]=1.
  - ROL: PASS1 in<<n; PASS2 rev(rev(in)<<(32-n)).
  - ROR: PASS1 rev(rev(in)<<n); PASS2 in<<(32-n).
  - n=0 rotate gives 32-n=32; shifter returns 0, so result=in. No special case needed.
- States:
  - IDLE -> PASS1 on accepted start.
  - PASS1: accumulator <= pass value. Next state is PASS2 for SHRA/ROL/ROR, otherwise DONE.
  - PASS2: accumulator <= accumulator | pass value; -> DONE.
  - DONE: result <= accumulator (registered at entry), done=1 for exactly this cycle; -> IDLE unconditionally.
- Latency:
  - Single-pass ops: done high in the 2nd cycle after the accepting edge.
  - Two-pass ops: done high in the 3rd cycle after the accepting edge.
  - Back-to-back throughput is 1 op per 3 or 4 cycles; start is accepted again in the cycle after DONE.
- done and busy are registered or state-decoded; neither has a combinational path from start.
- Exactly one shifter instance; no other adder/shifter in the datapath besides the 6-bit (32-n) subtractor.

Decomposition:
- Shared package/header: op encodings (SHL/SHR/SHRA/ROL/ROR), state encodings (IDLE, PASS1, PASS2, DONE), width constant 32.
- Sub-module: one instance of the existing alu_shift_left, plus a small combinational bit_reverse32 helper (two instances, input and output side).

Test Plan:
1. SHL in=0x00000019 amount=3 -> result 0x000000C8; done pulses 2 cycles after the accepting edge; busy high for 2 cycles.
2. SHR in=0x80000000 amount=31 -> 0x00000001; SHR in=0xFFFFFFFF amount=0x40 -> 0x00000000 (saturation, upper amount bits set).
3. SHRA:
   - in=0xF0000000 amount=4 -> 0xFF000000
   - in=0x70000000 amount=4 -> 0x07000000
   - in=0x80000000 amount=100 -> 0xFFFFFFFF
   - done 3 cycles after accept in all three cases.
4. Rotates:
   - ROL in=0x80000001 amount=1 -> 0x00000003
   - ROR in=0x00000001 amount=33 -> 0x80000000
   - ROL in=0x12345678 amount=0 -> 0x12345678
5. Handshake: assert start again with different operands during PASS1 and DONE -> ignored, first result unchanged, exactly one done pulse. Pass-through op=111 in=0xDEADBEEF -> result 0xDEADBEEF after 2 cycles.
6. Reset mid-operation: clr asserted during PASS2 of ROL -> busy=0, result=0 immediately (before the next edge), no done pulse. Next start after release completes normally.

Source files
------------

// File: rtl/alu_shift_sequencer_pkg.sv
// Shared encodings and helpers for the shift/rotate sequencer.
// The datapath width and the 6-bit shifter amount match the existing left shifter.
package alu_shift_sequencer_pkg;

    localparam int WIDTH = 32;

    localparam logic [2:0] OP_SHL  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHRA = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [WIDTH-1:0] rev32(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_shift_sequencer_shifter.sv
// Single 32-bit left barrel shifter; amounts of 32 and above produce zero.
// Purely combinational.
module alu_shift_sequencer_shifter
    import alu_shift_sequencer_pkg::*;
(
    input  logic [WIDTH-1:0] data,
    input  logic [5:0]       amt,
    output logic [WIDTH-1:0] shifted
);

    assign shifted = data << amt;

endmodule

// File: rtl/alu_shift_sequencer.sv
// Sequences one left shifter through one or two passes to implement SHL/SHR/SHRA/ROL/ROR.
// done pulses 2 cycles after accept for single-pass ops, 3 cycles for SHRA/ROL/ROR.
module alu_shift_sequencer
    import alu_shift_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_e           state, next_state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] in_q, amount_q, acc, acc_next;
    logic [5:0]       n, sh_amt;
    logic             rev_sel, use_ones, invert, two_pass;
    logic [WIDTH-1:0] src, sh_din, sh_dout, shifted, pass_val;

    always_comb begin
        n = 6'd0;
        case (op_q)
            OP_SHL, OP_SHR, OP_SHRA: n = (|amount_q[31:5]) ? 6'd32 : {1'b0, amount_q[4:0]};
            OP_ROL, OP_ROR:          n = {1'b0, amount_q[4:0]};
            default:                 n = 6'd0;
        endcase
    end

    assign two_pass = (op_q == OP_SHRA) || (op_q == OP_ROL) || (op_q == OP_ROR);

    // Right-going passes reverse around the left shifter; the SHRA sign mask is built from all-ones.
    always_comb begin
        rev_sel  = 1'b0;
        use_ones = 1'b0;
        invert   = 1'b0;
        sh_amt   = n;
        if (state == ST_PASS2) begin
            case (op_q)
                OP_SHRA: begin
                    rev_sel  = 1'b1;
                    use_ones = 1'b1;
                    invert   = 1'b1;
                end
                OP_ROL: begin
                    rev_sel = 1'b1;
                    sh_amt  = 6'd32 - n;
                end
                OP_ROR:  sh_amt = 6'd32 - n;
                default: ;
            endcase
        end else begin
            rev_sel = (op_q == OP_SHR) || (op_q == OP_SHRA) || (op_q == OP_ROR);
        end
    end

    assign src     = use_ones ? {WIDTH{1'b1}} : in_q;
    assign sh_din  = rev_sel ? rev32(src) : src;
    assign shifted = rev_sel ? rev32(sh_dout) : sh_dout;

    alu_shift_sequencer_shifter u_shifter (
        .data    (sh_din),
        .amt     (sh_amt),
        .shifted (sh_dout)
    );

    assign pass_val = invert ? (in_q[31] ? ~shifted : '0) : shifted;
    assign acc_next = (state == ST_PASS2) ? (acc | pass_val) : pass_val;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_PASS1;
            ST_PASS1: next_state = two_pass ? ST_PASS2 : ST_DONE;
            ST_PASS2: next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // result is loaded on the edge entering DONE, so it already holds the final accumulator value.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            op_q     <= '0;
            in_q     <= '0;
            amount_q <= '0;
            acc      <= '0;
            result   <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                op_q     <= op;
                in_q     <= in;
                amount_q <= amount;
                acc      <= '0;
            end else if (state == ST_PASS1 || state == ST_PASS2) begin
                acc <= acc_next;
                if (next_state == ST_DONE) result <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer: hand-computed vectors, latency, handshake and reset.
module tb_alu_shift_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in_data;
    logic [31:0] amount;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    alu_shift_sequencer dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .op     (op),
        .in     (in_data),
        .amount (amount),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one op and checks busy/done every cycle until return to IDLE.
    task automatic run_op(input logic [2:0] o, input logic [31:0] d, input logic [31:0] a,
                          input logic [31:0] exp, input int passes, input bit glitch,
                          input string tag);
        @(negedge clk);
        start = 1'b1; op = o; in_data = d; amount = a;
        for (int k = 1; k <= passes + 1; k++) begin
            @(negedge clk);
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_done"}, {31'd0, done}, (k == passes + 1) ? 32'd1 : 32'd0);
            if (k == passes + 1) check({tag, "_result"}, result, exp);
            if (glitch) begin
                start = 1'b1; op = 3'b000; in_data = 32'hFFFF_FFFF; amount = 32'd1;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
        check({tag, "_held"}, result, exp);
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; op = 3'b000; in_data = '0; amount = '0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        run_op(3'b000, 32'h0000_0019, 32'd3,   32'h0000_00C8, 1, 1'b0, "shl_3");
        run_op(3'b000, 32'h0000_0001, 32'd32,  32'h0000_0000, 1, 1'b0, "shl_32");
        run_op(3'b001, 32'h8000_0000, 32'd31,  32'h0000_0001, 1, 1'b0, "shr_31");
        run_op(3'b001, 32'hFFFF_FFFF, 32'h40,  32'h0000_0000, 1, 1'b0, "shr_sat");
        run_op(3'b010, 32'hF000_0000, 32'd4,   32'hFF00_0000, 2, 1'b0, "shra_neg");
        run_op(3'b010, 32'h7000_0000, 32'd4,   32'h0700_0000, 2, 1'b0, "shra_pos");
        run_op(3'b010, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF, 2, 1'b0, "shra_sat");
        run_op(3'b010, 32'h8000_0000, 32'd0,   32'h8000_0000, 2, 1'b0, "shra_0");
        run_op(3'b011, 32'h8000_0001, 32'd1,   32'h0000_0003, 2, 1'b0, "rol_1");
        run_op(3'b100, 32'h0000_0001, 32'd33,  32'h8000_0000, 2, 1'b0, "ror_33");
        run_op(3'b011, 32'h1234_5678, 32'd0,   32'h1234_5678, 2, 1'b0, "rol_0");
        run_op(3'b100, 32'h1234_5678, 32'd4,   32'h8123_4567, 2, 1'b0, "ror_4");
        run_op(3'b000, 32'h0000_0019, 32'd3,   32'h0000_00C8, 1, 1'b1, "shl_glitch");
        run_op(3'b011, 32'h8000_0001, 32'd1,   32'h0000_0003, 2, 1'b1, "rol_glitch");
        run_op(3'b111, 32'hDEAD_BEEF, 32'd5,   32'hDEAD_BEEF, 1, 1'b0, "pass_thru");

        // Reset during PASS2 of a rotate: outputs clear asynchronously and no done follows.
        @(negedge clk);
        start = 1'b1; op = 3'b011; in_data = 32'h0000_00F0; amount = 32'd8;
        @(negedge clk);
        start = 1'b0;
        check("mid_pass1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("mid_pass2_busy", {31'd0, busy}, 32'd1);
        clr = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_done", {31'd0, done}, 32'd0);
            check("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        run_op(3'b011, 32'h0000_00F0, 32'd8, 32'h0000_F000, 2, 1'b0, "after_rst_rol");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
